// File: rtl/zoom_pkg.sv
// Shared definitions for the zoom address generator, the frame buffer and the averaging datapath.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
// Contents: zoom mode encodings, controller state encoding, default frame geometry, effective-scale helper.
package zoom_pkg;

  localparam int DEF_IMG_W  = 160;
  localparam int DEF_IMG_H  = 120;
  localparam int DEF_ADDR_W = 17;
  localparam int DEF_MAX_K  = 2;

  localparam logic [1:0] MODE_COPY = 2'd0;
  localparam logic [1:0] MODE_DEC  = 2'd1;
  localparam logic [1:0] MODE_AVG  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Scale actually used for a pass: COPY (encodings 0 and 3) ignores k,
  // and oversized k saturates to the largest supported block.
  function automatic logic [1:0] eff_k(input logic [1:0] mode, input logic [1:0] k,
                                       input int max_k);
    logic [1:0] r;
    if (mode != MODE_DEC && mode != MODE_AVG) r = 2'd0;
    else if (int'(k) > max_k)                 r = 2'(max_k);
    else                                      r = k;
    return r;
  endfunction

endpackage

// File: rtl/zoom_axis_cnt.sv
// Wrap counter for one scan axis: counts 0..i_limit, returns to 0 on the step after the limit.
// Latency: count updates on the edge after i_step/i_clr; o_nxt shows that value combinationally.
// Backpressure: holds its count whenever i_step is low.
// Ports: i_clk/i_rst (sync, active-high), i_clr (restart at 0), i_step (advance), i_limit (last value),
//        o_nxt (value after this edge), o_wrap (count currently at i_limit).
module zoom_axis_cnt #(
  parameter int CW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_step,
  input  logic [CW-1:0] i_limit,
  output logic [CW-1:0] o_nxt,
  output logic          o_wrap
);

  logic [CW-1:0] r_cnt;

  assign o_wrap = (r_cnt == i_limit);

  always_comb begin
    o_nxt = r_cnt;
    if (i_clr)       o_nxt = '0;
    else if (i_step) o_nxt = o_wrap ? '0 : r_cnt + CW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_cnt <= '0;
    else       r_cnt <= o_nxt;
  end

endmodule

// File: rtl/zoom_addr_gen.sv
// Zoom address generator: walks the source frame, emitting source read and destination write addresses.
// Latency: first tap is presented the cycle after an accepted start; each accepted tap advances one edge later.
// Backpressure: i_en low freezes every output; done pulses one cycle after the final tap is accepted.
// Ports: i_clk, i_rst (sync, active-high), i_start, i_en, i_mode[1:0], i_k[1:0] in;
//        o_src_addr, o_dst_addr [ADDR_W-1:0], o_first_tap, o_last_tap, o_processing, o_done out.
module zoom_addr_gen
  import zoom_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int MAX_K  = DEF_MAX_K
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_en,
  input  logic [1:0]        i_mode,
  input  logic [1:0]        i_k,
  output logic [ADDR_W-1:0] o_src_addr,
  output logic [ADDR_W-1:0] o_dst_addr,
  output logic              o_first_tap,
  output logic              o_last_tap,
  output logic              o_processing,
  output logic              o_done
);

  localparam int TW  = (MAX_K > 0) ? MAX_K : 1;
  localparam int DXW = $clog2(IMG_W);
  localparam int DYW = $clog2(IMG_H);

  state_t            r_state;
  logic [TW-1:0]     r_lim_t;
  logic [DXW-1:0]    r_lim_dx;
  logic [DYW-1:0]    r_lim_dy;
  logic [ADDR_W-1:0] r_pix_step, r_row_step;
  // Source bases: start of current block row, of current block, of current tap row inside the block.
  logic [ADDR_W-1:0] r_row_base, r_pix_base, r_tap_base;
  logic [ADDR_W-1:0] r_src, r_dst;
  logic              r_first, r_last, r_proc, r_done;

  // Pass geometry derived from the inputs at the moment start is accepted.
  logic [1:0]        w_ek;
  logic [TW-1:0]     w_lim_t;
  logic [DXW-1:0]    w_lim_dx;
  logic [DYW-1:0]    w_lim_dy;

  assign w_ek     = eff_k(i_mode, i_k, MAX_K);
  assign w_lim_t  = (i_mode == MODE_AVG) ? TW'((1 << w_ek) - 1) : '0;
  assign w_lim_dx = DXW'((IMG_W >> w_ek) - 1);
  assign w_lim_dy = DYW'((IMG_H >> w_ek) - 1);

  logic              w_start, w_adv;
  logic              w_tx_wrap, w_ty_wrap, w_dx_wrap, w_dy_wrap;
  logic              w_step_ty, w_step_dx, w_step_dy, w_final;
  logic [TW-1:0]     w_tx_nxt, w_ty_nxt;
  logic [DXW-1:0]    w_dx_nxt;
  logic [DYW-1:0]    w_dy_nxt;
  logic              w_first_nxt, w_last_nxt;
  logic [ADDR_W-1:0] w_tap_base_nxt, w_pix_base_nxt, w_row_base_nxt;

  assign w_start   = (r_state == ST_IDLE) && i_start;
  assign w_adv     = (r_state == ST_RUN) && i_en;
  // Carry chain, fastest axis first: tx -> ty -> dx -> dy.
  assign w_step_ty = w_adv && w_tx_wrap;
  assign w_step_dx = w_step_ty && w_ty_wrap;
  assign w_step_dy = w_step_dx && w_dx_wrap;
  assign w_final   = w_step_dy && w_dy_wrap;

  zoom_axis_cnt #(.CW(TW)) u_tx (
    .i_clk(i_clk), .i_rst(i_rst), .i_clr(w_start), .i_step(w_adv),
    .i_limit(r_lim_t), .o_nxt(w_tx_nxt), .o_wrap(w_tx_wrap));
  zoom_axis_cnt #(.CW(TW)) u_ty (
    .i_clk(i_clk), .i_rst(i_rst), .i_clr(w_start), .i_step(w_step_ty),
    .i_limit(r_lim_t), .o_nxt(w_ty_nxt), .o_wrap(w_ty_wrap));
  zoom_axis_cnt #(.CW(DXW)) u_dx (
    .i_clk(i_clk), .i_rst(i_rst), .i_clr(w_start), .i_step(w_step_dx),
    .i_limit(r_lim_dx), .o_nxt(w_dx_nxt), .o_wrap(w_dx_wrap));
  zoom_axis_cnt #(.CW(DYW)) u_dy (
    .i_clk(i_clk), .i_rst(i_rst), .i_clr(w_start), .i_step(w_step_dy),
    .i_limit(r_lim_dy), .o_nxt(w_dy_nxt), .o_wrap(w_dy_wrap));

  // Pixel axes only feed the carry chain; their next-count values are folded here.
  logic w_pix_nxt_unused;
  assign w_pix_nxt_unused = ^{w_dx_nxt, w_dy_nxt};

  // Tap markers for the tap being moved to.
  assign w_first_nxt = (w_tx_nxt == '0) && (w_ty_nxt == '0);
  assign w_last_nxt  = (w_tx_nxt == r_lim_t) && (w_ty_nxt == r_lim_t);

  assign w_tap_base_nxt = r_tap_base + ADDR_W'(IMG_W);
  assign w_pix_base_nxt = r_pix_base + r_pix_step;
  assign w_row_base_nxt = r_row_base + r_row_step;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_lim_t    <= '0;
      r_lim_dx   <= '0;
      r_lim_dy   <= '0;
      r_pix_step <= '0;
      r_row_step <= '0;
      r_row_base <= '0;
      r_pix_base <= '0;
      r_tap_base <= '0;
      r_src      <= '0;
      r_dst      <= '0;
      r_first    <= 1'b0;
      r_last     <= 1'b0;
      r_proc     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state    <= ST_RUN;
            r_lim_t    <= w_lim_t;
            r_lim_dx   <= w_lim_dx;
            r_lim_dy   <= w_lim_dy;
            r_pix_step <= ADDR_W'(1 << w_ek);
            r_row_step <= ADDR_W'(IMG_W << w_ek);
            r_row_base <= '0;
            r_pix_base <= '0;
            r_tap_base <= '0;
            r_src      <= '0;
            r_dst      <= '0;
            r_first    <= 1'b1;
            r_last     <= (w_lim_t == '0);
            r_proc     <= 1'b1;
          end
        end
        ST_RUN: begin
          if (i_en) begin
            if (w_final) begin
              // Addresses keep their last values; only the control flags change.
              r_state <= ST_DONE;
              r_proc  <= 1'b0;
              r_done  <= 1'b1;
              r_first <= 1'b0;
              r_last  <= 1'b0;
            end else begin
              r_first <= w_first_nxt;
              r_last  <= w_last_nxt;
              if (!w_tx_wrap) begin
                r_src <= r_src + ADDR_W'(1);
              end else if (!w_ty_wrap) begin
                r_tap_base <= w_tap_base_nxt;
                r_src      <= w_tap_base_nxt;
              end else if (!w_dx_wrap) begin
                r_pix_base <= w_pix_base_nxt;
                r_tap_base <= w_pix_base_nxt;
                r_src      <= w_pix_base_nxt;
                r_dst      <= r_dst + ADDR_W'(1);
              end else begin
                r_row_base <= w_row_base_nxt;
                r_pix_base <= w_row_base_nxt;
                r_tap_base <= w_row_base_nxt;
                r_src      <= w_row_base_nxt;
                r_dst      <= r_dst + ADDR_W'(1);
              end
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_src_addr   = r_src;
  assign o_dst_addr   = r_dst;
  assign o_first_tap  = r_first;
  assign o_last_tap   = r_last;
  assign o_processing = r_proc;
  assign o_done       = r_done;

endmodule

// File: tb/tb_zoom_addr_gen.sv
// Self-checking bench for zoom_addr_gen: directed pass sequence with random enable and mid-run control events,
// every presented tap compared against a tap list computed directly from the frame geometry.
module tb_zoom_addr_gen;
  import zoom_pkg::*;

  localparam int W  = 160;
  localparam int H  = 120;
  localparam int AW = 17;
  localparam int MK = 2;

  logic          clk = 1'b0;
  logic          rst, start, en;
  logic [1:0]    mode, k;
  logic [AW-1:0] src_addr, dst_addr;
  logic          first_tap, last_tap, processing, done;

  always #5 clk = ~clk;

  zoom_addr_gen #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .MAX_K(MK)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_en(en), .i_mode(mode), .i_k(k),
    .o_src_addr(src_addr), .o_dst_addr(dst_addr), .o_first_tap(first_tap),
    .o_last_tap(last_tap), .o_processing(processing), .o_done(done));

  typedef struct packed {
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic          first;
    logic          last;
  } tap_t;

  tap_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected tap list for one pass, straight from the addressing rules.
  task automatic build(input int md, input int kk);
    int ek, t, s;
    tap_t e;
    exp_q.delete();
    ek = (md == 1 || md == 2) ? ((kk > MK) ? MK : kk) : 0;
    s  = 1 << ek;
    t  = (md == 2) ? s : 1;
    for (int dy = 0; dy < H / s; dy++)
      for (int dx = 0; dx < W / s; dx++)
        for (int ty = 0; ty < t; ty++)
          for (int tx = 0; tx < t; tx++) begin
            e.src   = AW'((dy * s + ty) * W + dx * s + tx);
            e.dst   = AW'(dy * (W / s) + dx);
            e.first = (tx == 0 && ty == 0);
            e.last  = (tx == t - 1 && ty == t - 1);
            exp_q.push_back(e);
          end
  endtask

  // Entered and left at a falling edge with the DUT idle; start is raised immediately.
  task automatic run_pass(input int md, input int kk, input int en_pct, input int pulse_at,
                          input int rst_at, input bit start_in_done);
    int idx = 0;
    int cyc = 0;
    int n;
    build(md, kk);
    n = exp_q.size();
    start = 1'b1; mode = 2'(md); k = 2'(kk); en = 1'b0;
    @(negedge clk);
    start = 1'b0;
    mode  = 2'($urandom);
    k     = 2'($urandom);
    while (idx < n && cyc < 8 * n + 100) begin
      chk("processing", processing, 1);
      chk("done_low", done, 0);
      chk("tap", {src_addr, dst_addr, first_tap, last_tap}, exp_q[idx]);
      if (idx == rst_at) begin
        rst = 1'b1; en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; en = 1'b0;
        chk("rst_outputs", {processing, done, first_tap, last_tap, src_addr, dst_addr}, 0);
        repeat (4) begin
          @(negedge clk);
          chk("rst_no_done", {processing, done}, 0);
        end
        return;
      end
      start = (idx == pulse_at);
      en    = ($urandom_range(99) < en_pct);
      @(posedge clk);
      if (en) idx++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; en = 1'b0;
    chk("pass_len", idx, n);
    if (idx != n) return;
    chk("done_pulse", {processing, done}, 2'b01);
    chk("final_src", src_addr, exp_q[n-1].src);
    chk("final_dst", dst_addr, exp_q[n-1].dst);
    start = start_in_done;
    @(negedge clk);
    start = 1'b0;
    chk("done_one_cycle", {processing, done}, 0);
    chk("hold_src", src_addr, exp_q[n-1].src);
    if (start_in_done) begin
      @(negedge clk);
      chk("start_in_done_ignored", {processing, done}, 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; en = 1'b0; mode = MODE_COPY; k = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_outputs", {processing, done, first_tap, last_tap, src_addr, dst_addr}, 0);

    // start coinciding with reset must not begin a pass
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("start_with_rst", {processing, done}, 0);
    @(negedge clk);
    chk("start_with_rst_later", {processing, done}, 0);

    // COPY (k ignored), then back-to-back DEC k=1 with a start pulse mid-run
    run_pass(0, 2, 100, -1, -1, 1'b0);
    run_pass(1, 1, 100, 100, -1, 1'b0);
    // AVG k=1 with a pseudo-random enable
    run_pass(2, 1, 85, -1, -1, 1'b0);
    // AVG k=3 saturates to 4x4 blocks; start during the done cycle is dropped
    run_pass(2, 3, 100, -1, -1, 1'b1);
    // reset after 100 taps, then a fresh pass
    run_pass(2, 1, 90, -1, 100, 1'b0);
    run_pass(1, 2, 100, -1, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
